shared_div_scheduler: RTL and testbench



---
 rtl/gpu_div_pkg.sv | 22 ++
 rtl/div_iter_core.sv | 77 +++++++
 rtl/shared_div_scheduler.sv | 170 +++++++++++++++++
 tb/tb_shared_div_scheduler.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_div_pkg.sv
// Shared types and helpers for the shared iterative divider scheduler.
// Optional feature macro: DIV_FASTPATH_EN (trivial divisors bypass the iteration).
package gpu_div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // All-ones quotient returned when the divisor is zero, for widths up to 32.
    function automatic logic [31:0] div_zero_quotient(input int unsigned width);
        logic [31:0] q;
        if (width >= 32) begin
            q = '1;
        end else begin
            q = (32'd1 << width) - 32'd1;
        end
        return q;
    endfunction

endpackage

// File: rtl/div_iter_core.sv
// Restoring shift/subtract divider, one quotient bit per clock, MSB first.
// The first quotient bit is produced on the start edge straight from the
// operand inputs, so the last bit lands DATA_BITS-1 edges later and valid
// pulses in the cycle after that final edge.
module div_iter_core #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] dividend,
    input  logic [DATA_BITS-1:0] divisor,
    output logic [DATA_BITS-1:0] quotient,
    output logic [DATA_BITS-1:0] remainder,
    output logic                 valid
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    logic [DATA_BITS-1:0] rem_q;
    logic [DATA_BITS-1:0] quo_q;
    logic [DATA_BITS-1:0] dvsr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 valid_q;

    logic [DATA_BITS-1:0] src_rem;
    logic [DATA_BITS-1:0] src_quo;
    logic [DATA_BITS-1:0] src_dvsr;
    logic [DATA_BITS:0]   shifted;
    logic [DATA_BITS:0]   diff;
    logic                 fits;
    logic [DATA_BITS-1:0] next_rem;
    logic [DATA_BITS-1:0] next_quo;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits.
    always_comb begin
        src_rem  = start ? '0       : rem_q;
        src_quo  = start ? dividend : quo_q;
        src_dvsr = start ? divisor  : dvsr_q;
        shifted  = {src_rem, src_quo[DATA_BITS-1]};
        diff     = shifted - {1'b0, src_dvsr};
        fits     = (shifted >= {1'b0, src_dvsr});
        next_rem = fits ? diff[DATA_BITS-1:0] : shifted[DATA_BITS-1:0];
        next_quo = {src_quo[DATA_BITS-2:0], fits};
    end

    // Iteration registers: load and take the first step on start, then
    // keep stepping until the bit counter runs out.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (start) begin
            rem_q   <= next_rem;
            quo_q   <= next_quo;
            dvsr_q  <= divisor;
            cnt_q   <= CNT_W'(DATA_BITS - 1);
            valid_q <= 1'b0;
        end else if (cnt_q != '0) begin
            rem_q   <= next_rem;
            quo_q   <= next_quo;
            cnt_q   <= cnt_q - 1'b1;
            valid_q <= (cnt_q == CNT_W'(1));
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign valid     = valid_q;

endmodule

// File: rtl/shared_div_scheduler.sv
// Round-robin arbiter and sequencer sharing one iterative divider among
// THREADS requesting ALUs. One division is in flight at a time.
// Optional feature macro: DIV_FASTPATH_EN -- divisors 0 and 1 skip the RUN
// phase and complete one cycle after the grant.
//
// Handshake: req[i] is a level request sampled only while the FSM is idle;
// operands are captured on the grant edge. done[i] is a single-cycle pulse
// during which result slice i and div_zero[i] already hold the new values.
// A req still high in the cycle after done is treated as a new request.
module shared_div_scheduler
    import gpu_div_pkg::*;
#(
    parameter int THREADS   = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [THREADS-1:0]             req,
    input  logic [THREADS*DATA_BITS-1:0]   rs_flat,
    input  logic [THREADS*DATA_BITS-1:0]   rt_flat,
    output logic [THREADS-1:0]             done,
    output logic [THREADS*DATA_BITS-1:0]   result_flat,
    output logic                           busy,
    output logic [THREADS-1:0]             div_zero,
    output div_state_t                     fsm_state
);

    localparam int IDX_W = (THREADS > 1) ? $clog2(THREADS) : 1;
    localparam logic [DATA_BITS-1:0] ZERO_Q = DATA_BITS'(div_zero_quotient(DATA_BITS));

    div_state_t state;
    div_state_t state_next;

    logic [IDX_W-1:0]             rr_ptr;
    logic [IDX_W-1:0]             grant_idx;
    logic                         zero_q;
    logic [THREADS*DATA_BITS-1:0] result_q;
    logic [THREADS-1:0]           div_zero_q;

    logic                 any_req;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     cand_idx;
    logic [DATA_BITS-1:0] pick_rs;
    logic [DATA_BITS-1:0] pick_rt;
    logic                 pick_zero;
    logic                 fast_hit;
    logic                 grant_now;
    logic                 core_start;

    logic [DATA_BITS-1:0] core_quotient;
    logic [DATA_BITS-1:0] core_remainder_unused;
    logic                 core_valid;

    // Rotating-priority search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        any_req  = 1'b0;
        pick_idx = '0;
        cand_idx = '0;
        for (int k = 0; k < THREADS; k++) begin
            cand_idx = IDX_W'((int'(rr_ptr) + k) % THREADS);
            if (!any_req && req[cand_idx]) begin
                any_req  = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    assign pick_rs   = rs_flat[pick_idx*DATA_BITS +: DATA_BITS];
    assign pick_rt   = rt_flat[pick_idx*DATA_BITS +: DATA_BITS];
    assign pick_zero = (pick_rt == '0);
    assign grant_now = (state == DIV_IDLE) && any_req;

`ifdef DIV_FASTPATH_EN
    // Divisor 0 or 1 has a trivial quotient, so no iteration is needed.
    assign fast_hit = (pick_rt[DATA_BITS-1:1] == '0);
`else
    assign fast_hit = 1'b0;
`endif

    assign core_start = grant_now && !fast_hit;

    div_iter_core #(
        .DATA_BITS (DATA_BITS)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .start     (core_start),
        .dividend  (pick_rs),
        .divisor   (pick_rt),
        .quotient  (core_quotient),
        .remainder (core_remainder_unused),
        .valid     (core_valid)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: grant from idle, iterate until the core reports the
    // last bit, spend one cycle presenting the result.
    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: begin
                if (any_req) begin
                    state_next = fast_hit ? DIV_DONE : DIV_RUN;
                end
            end
            DIV_RUN: begin
                if (core_valid) begin
                    state_next = DIV_DONE;
                end
            end
            DIV_DONE: begin
                state_next = DIV_IDLE;
            end
            default: begin
                state_next = DIV_IDLE;
            end
        endcase
    end

    // FSM outputs: busy outside idle, one-hot done pulse for the granted thread.
    always_comb begin
        done = '0;
        busy = (state != DIV_IDLE);
        if (state == DIV_DONE) begin
            done[grant_idx] = 1'b1;
        end
    end

    // Grant bookkeeping: remember who owns the divider and advance the pointer
    // past it so every other requester gets a turn first.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            grant_idx <= '0;
            zero_q    <= 1'b0;
        end else if (grant_now) begin
            grant_idx <= pick_idx;
            zero_q    <= pick_zero;
            rr_ptr    <= (int'(pick_idx) == THREADS - 1) ? '0 : pick_idx + 1'b1;
        end
    end

    // Result registers: only the granted slice is written, on the edge that
    // enters DONE, so the value is visible alongside the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q   <= '0;
            div_zero_q <= '0;
        end else if (grant_now && fast_hit) begin
            result_q[pick_idx*DATA_BITS +: DATA_BITS] <= pick_zero ? ZERO_Q : pick_rs;
            div_zero_q[pick_idx]                      <= pick_zero;
        end else if ((state == DIV_RUN) && core_valid) begin
            result_q[grant_idx*DATA_BITS +: DATA_BITS] <= zero_q ? ZERO_Q : core_quotient;
            div_zero_q[grant_idx]                      <= zero_q;
        end
    end

    assign result_flat = result_q;
    assign div_zero    = div_zero_q;
    assign fsm_state   = state;

endmodule

// File: tb/tb_shared_div_scheduler.sv
// Self-checking bench for shared_div_scheduler: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_shared_div_scheduler;
  import gpu_div_pkg::*;

  localparam int T = 4;
  localparam int W = 8;
`ifdef DIV_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic [T-1:0]   req;
  logic [T*W-1:0] rs_flat;
  logic [T*W-1:0] rt_flat;
  logic [T-1:0]   done;
  logic [T*W-1:0] result_flat;
  logic           busy;
  logic [T-1:0]   div_zero;
  div_state_t     fsm_state;

  always #5 clk = ~clk;

  shared_div_scheduler #(.THREADS(T), .DATA_BITS(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .rs_flat     (rs_flat),
    .rt_flat     (rt_flat),
    .done        (done),
    .result_flat (result_flat),
    .busy        (busy),
    .div_zero    (div_zero),
    .fsm_state   (fsm_state)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // A division occupies the divider from its grant until its done cycle;
  // m_wait counts the cycles left until that done cycle.
  int m_active;
  int m_wait;
  int m_grant;
  int m_rr;
  int m_q;
  int m_z;
  int m_res[T];
  int m_zero[T];
  logic [W-1:0] exp_q[$];
  int           exp_thr_q[$];

  task automatic model_apply();
    m_res[m_grant]  = m_q;
    m_zero[m_grant] = m_z;
  endtask

  task automatic model_edge();
    int a;
    int b;
    int found;
    if (reset) begin
      m_active = 0;
      m_wait = 0;
      m_rr = 0;
      for (int i = 0; i < T; i++) begin
        m_res[i] = 0;
        m_zero[i] = 0;
      end
      exp_q.delete();
      exp_thr_q.delete();
    end else if (m_active != 0) begin
      if (m_wait == 0) begin
        m_active = 0;
      end else begin
        m_wait--;
        if (m_wait == 0) model_apply();
      end
    end else begin
      found = -1;
      for (int k = 0; k < T; k++) begin
        if (found < 0 && req[(m_rr + k) % T]) found = (m_rr + k) % T;
      end
      if (found >= 0) begin
        a = int'(rs_flat[found*W +: W]);
        b = int'(rt_flat[found*W +: W]);
        m_grant = found;
        m_rr = (found + 1) % T;
        m_z = (b == 0) ? 1 : 0;
        m_q = (b == 0) ? ((1 << W) - 1) : (a / b);
        m_active = 1;
        m_wait = (FAST && b <= 1) ? 0 : W;
        exp_q.push_back(W'(m_q));
        exp_thr_q.push_back(found);
        if (m_wait == 0) model_apply();
      end
    end
  endtask

  function automatic logic [T*W-1:0] model_result_flat();
    logic [T*W-1:0] v;
    for (int i = 0; i < T; i++) v[i*W +: W] = W'(m_res[i]);
    return v;
  endfunction

  function automatic logic [T-1:0] model_div_zero();
    logic [T-1:0] v;
    for (int i = 0; i < T; i++) v[i] = (m_zero[i] != 0);
    return v;
  endfunction

  function automatic logic [T-1:0] model_done();
    logic [T-1:0] v;
    v = '0;
    if (m_active != 0 && m_wait == 0) v[m_grant] = 1'b1;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Request one division on thread thr, wait for its done, then release req.
  task automatic run_one(input int thr, input int a, input int b, output int lat);
    req = '0;
    rs_flat[thr*W +: W] = W'(a);
    rt_flat[thr*W +: W] = W'(b);
    req[thr] = 1'b1;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (done[thr]) begin
        lat = n;
        break;
      end
    end
    req[thr] = 1'b0;
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rs_flat = '0;
    rt_flat = '0;
    do_reset();
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++;
    if (done !== '0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++;
    if (result_flat !== '0) begin errors++; $display("FAIL reset_result got=%h want=0", result_flat); end
    checks++;
    if (div_zero !== '0) begin errors++; $display("FAIL reset_div_zero got=%b want=0", div_zero); end
    checks++;
    if (fsm_state !== DIV_IDLE) begin errors++; $display("FAIL reset_state got=%0d want=%0d", fsm_state, DIV_IDLE); end
  endtask

  task automatic test_basic();
    int lat;
    run_one(0, 200, 7, lat);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL basic_latency got=%0d want=9", lat); end
    checks++;
    if (result_flat[0 +: W] !== 8'd28) begin errors++; $display("FAIL basic_result got=%0d want=28", result_flat[0 +: W]); end
    checks++;
    if (div_zero[0] !== 1'b0) begin errors++; $display("FAIL basic_div_zero got=%b want=0", div_zero[0]); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_after got=%b want=0", busy); end
  endtask

  task automatic test_div_zero();
    int lat;
    int want_lat;
    want_lat = FAST ? 1 : 9;
    run_one(1, 5, 0, lat);
    checks++;
    if (lat !== want_lat) begin errors++; $display("FAIL dz_latency got=%0d want=%0d", lat, want_lat); end
    checks++;
    if (result_flat[W +: W] !== 8'hFF) begin errors++; $display("FAIL dz_result got=%h want=ff", result_flat[W +: W]); end
    checks++;
    if (div_zero[1] !== 1'b1) begin errors++; $display("FAIL dz_flag got=%b want=1", div_zero[1]); end
    run_one(1, 9, 3, lat);
    checks++;
    if (result_flat[W +: W] !== 8'd3) begin errors++; $display("FAIL dz_next_result got=%0d want=3", result_flat[W +: W]); end
    checks++;
    if (div_zero[1] !== 1'b0) begin errors++; $display("FAIL dz_next_flag got=%b want=0", div_zero[1]); end
    checks++;
    if (result_flat[0 +: W] !== 8'd28) begin errors++; $display("FAIL dz_other_slice_hold got=%0d want=28", result_flat[0 +: W]); end
  endtask

  task automatic test_simultaneous();
    int ev_thr[3];
    int ev_cyc[3];
    int ev_res[3];
    int nev;
    int want_thr[3];
    int want_cyc[3];
    int want_res[3];
    want_thr = '{0, 2, 0};
    want_cyc = '{9, 19, 29};
    want_res = '{10, 10, 11};
    do_reset();
    nev = 0;
    rs_flat[0 +: W] = 8'd100; rt_flat[0 +: W] = 8'd10;
    rs_flat[2*W +: W] = 8'd50; rt_flat[2*W +: W] = 8'd5;
    req = 4'b0101;
    for (int n = 1; n <= 60 && nev < 3; n++) begin
      step();
      for (int i = 0; i < T; i++) begin
        if (done[i] && nev < 3) begin
          ev_thr[nev] = i;
          ev_cyc[nev] = n;
          ev_res[nev] = int'(result_flat[i*W +: W]);
          nev++;
          if (i == 0 && nev == 1) begin
            rs_flat[0 +: W] = 8'd77; rt_flat[0 +: W] = 8'd7;
          end else begin
            req[i] = 1'b0;
          end
        end
      end
    end
    req = '0;
    step();
    checks++;
    if (nev !== 3) begin errors++; $display("FAIL simul_event_count got=%0d want=3", nev); end
    for (int e = 0; e < nev; e++) begin
      checks++;
      if (ev_thr[e] !== want_thr[e] || ev_cyc[e] !== want_cyc[e] || ev_res[e] !== want_res[e])
        begin
          errors++;
          $display("FAIL simul_event%0d got thr=%0d cyc=%0d res=%0d want thr=%0d cyc=%0d res=%0d",
                   e, ev_thr[e], ev_cyc[e], ev_res[e], want_thr[e], want_cyc[e], want_res[e]);
        end
    end
  endtask

  task automatic test_all_hold();
    int ev_thr[5];
    int ev_cyc[5];
    int ev_res[5];
    int nev;
    int want_thr[5];
    want_thr = '{0, 1, 2, 3, 0};
    do_reset();
    nev = 0;
    for (int i = 0; i < T; i++) begin
      rs_flat[i*W +: W] = W'(i * 30 + 20);
      rt_flat[i*W +: W] = W'(i + 2);
    end
    req = 4'b1111;
    for (int n = 1; n <= 80 && nev < 5; n++) begin
      step();
      for (int i = 0; i < T; i++) begin
        if (done[i] && nev < 5) begin
          ev_thr[nev] = i;
          ev_cyc[nev] = n;
          ev_res[nev] = int'(result_flat[i*W +: W]);
          nev++;
        end
      end
    end
    req = '0;
    step();
    checks++;
    if (nev !== 5) begin errors++; $display("FAIL hold_event_count got=%0d want=5", nev); end
    for (int e = 0; e < nev; e++) begin
      checks++;
      if (ev_thr[e] !== want_thr[e] || ev_cyc[e] !== 9 + 10 * e ||
          ev_res[e] !== (want_thr[e] * 30 + 20) / (want_thr[e] + 2))
        begin
          errors++;
          $display("FAIL hold_event%0d got thr=%0d cyc=%0d res=%0d want thr=%0d cyc=%0d res=%0d",
                   e, ev_thr[e], ev_cyc[e], ev_res[e], want_thr[e], 9 + 10 * e,
                   (want_thr[e] * 30 + 20) / (want_thr[e] + 2));
        end
    end
  endtask

  task automatic test_reset_mid_run();
    int first_thr;
    int first_cyc;
    int saw_done;
    saw_done = 0;
    rs_flat[W +: W] = 8'd13; rt_flat[W +: W] = 8'd3;
    req = 4'b0010;
    step();
    for (int n = 0; n < 3; n++) begin
      step();
      if (done !== '0) saw_done = 1;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", busy); end
    checks++;
    if (done !== '0 || saw_done !== 0) begin errors++; $display("FAIL midrst_done got=%b early=%0d want=0", done, saw_done); end
    checks++;
    if (result_flat !== '0) begin errors++; $display("FAIL midrst_result got=%h want=0", result_flat); end
    checks++;
    if (div_zero !== '0) begin errors++; $display("FAIL midrst_div_zero got=%b want=0", div_zero); end
    // With rr_ptr back at 0, thread 1 must win over thread 3.
    rs_flat[W +: W] = 8'd40; rt_flat[W +: W] = 8'd4;
    rs_flat[3*W +: W] = 8'd60; rt_flat[3*W +: W] = 8'd6;
    req = 4'b1010;
    first_thr = -1;
    first_cyc = -1;
    for (int n = 1; n <= 30 && first_thr < 0; n++) begin
      step();
      for (int i = 0; i < T; i++) begin
        if (done[i] && first_thr < 0) begin
          first_thr = i;
          first_cyc = n;
        end
      end
    end
    req = '0;
    step();
    checks++;
    if (first_thr !== 1 || first_cyc !== 9) begin
      errors++;
      $display("FAIL midrst_rr_ptr got thr=%0d cyc=%0d want thr=1 cyc=9", first_thr, first_cyc);
    end
  endtask

  task automatic test_fastpath();
    int lat;
    int want_lat;
    want_lat = FAST ? 1 : 9;
    run_one(3, 9, 1, lat);
    checks++;
    if (lat !== want_lat) begin errors++; $display("FAIL fast_latency got=%0d want=%0d", lat, want_lat); end
    checks++;
    if (result_flat[3*W +: W] !== 8'd9) begin errors++; $display("FAIL fast_result got=%0d want=9", result_flat[3*W +: W]); end
    checks++;
    if (div_zero[3] !== 1'b0) begin errors++; $display("FAIL fast_div_zero got=%b want=0", div_zero[3]); end
  endtask

  task automatic test_random();
    logic [T-1:0]   want_done;
    logic [W-1:0]   sb_q;
    int             sb_thr;
    int             r;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      // drive next cycle's inputs
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < T; i++) begin
        if (done[i]) req[i] = 1'($urandom_range(0, 1));
        else if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 63) == 0) req[i] = 1'b0;
        rs_flat[i*W +: W] = W'($urandom_range(0, 255));
        r = $urandom_range(0, 7);
        rt_flat[i*W +: W] = (r == 0) ? 8'd0 : (r == 1) ? 8'd1 : W'($urandom_range(0, 255));
      end
      step();
      want_done = model_done();
      checks++;
      if (busy !== (m_active != 0)) begin errors++; $display("FAIL rnd_busy c=%0d got=%b want=%0d", c, busy, m_active); end
      checks++;
      if (done !== want_done) begin errors++; $display("FAIL rnd_done c=%0d got=%b want=%b", c, done, want_done); end
      checks++;
      if (result_flat !== model_result_flat()) begin
        errors++; $display("FAIL rnd_result c=%0d got=%h want=%h", c, result_flat, model_result_flat());
      end
      checks++;
      if (div_zero !== model_div_zero()) begin
        errors++; $display("FAIL rnd_div_zero c=%0d got=%b want=%b", c, div_zero, model_div_zero());
      end
      if (want_done !== '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_scoreboard_empty c=%0d got=empty want=entry", c);
        end else begin
          sb_q = exp_q.pop_front();
          sb_thr = exp_thr_q.pop_front();
          if (result_flat[sb_thr*W +: W] !== sb_q) begin
            errors++;
            $display("FAIL rnd_sb_quotient c=%0d thr=%0d got=%0d want=%0d", c, sb_thr, result_flat[sb_thr*W +: W], sb_q);
          end
        end
      end
    end
    reset = 1'b0;
    req = '0;
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    req = '0;
    rs_flat = '0;
    rt_flat = '0;
    m_active = 0; m_wait = 0; m_grant = 0; m_rr = 0; m_q = 0; m_z = 0;
    for (int i = 0; i < T; i++) begin m_res[i] = 0; m_zero[i] = 0; end
    test_reset();
    test_basic();
    test_div_zero();
    test_simultaneous();
    test_all_hold();
    test_reset_mid_run();
    test_fastpath();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
